// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences the shared ID-stage branch comparator, redirects on taken branches, counts branches
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   br_valid, br_op          ID stage branch and its opcode (BEQ/BNE/BLEZ/BGTZ/BGEZ)
//   br_target                computed branch target
//   opnd_ready               source operands are hazard-free
//   cmp_result               comparator outcome, valid the cycle after cmp_en
//   cmp_en, cmp_select       comparator strobe and function code
//   stall, flush             front-end hold and IF/ID squash
//   redirect_valid/_pc       PC redirect for taken branches
//   illegal_op               br_valid with an unsupported opcode
//   br_count, taken_count    saturating branch statistics
module branch_resolve_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic [4:0]        br_op,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              opnd_ready,
    input  logic              cmp_result,
    output logic              cmp_en,
    output logic [5:0]        cmp_select,
    output logic              stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);
    typedef enum logic [1:0] {IDLE, WAIT, COMPARE, RESOLVE} state_t;
    state_t state, next_state;
    logic [4:0] op_q;
    logic [ADDR_W-1:0] target_q;
    logic legal, accept;
    assign legal = br_op >= 5'd6 && br_op <= 5'd10;
    always_comb begin
        next_state = state;
        accept = 1'b0;
        stall = 1'b0;
        cmp_en = 1'b0;
        redirect_valid = 1'b0;
        illegal_op = 1'b0;
        case (state)
            IDLE: begin
                accept = br_valid && legal;
                illegal_op = br_valid && !legal;
                stall = accept;
                next_state = accept ? (opnd_ready ? COMPARE : WAIT) : IDLE;
            end
            WAIT: begin
                stall = 1'b1;
                next_state = opnd_ready ? COMPARE : WAIT;
            end
            COMPARE: begin
                stall = 1'b1;
                cmp_en = 1'b1;
                next_state = RESOLVE;
            end
            default: begin
                redirect_valid = cmp_result;
                next_state = IDLE;
            end
        endcase
        // reset behaves like IDLE for stall/illegal_op but never starts or finishes a branch
        if (rst) begin
            next_state = IDLE;
            accept = 1'b0;
            cmp_en = 1'b0;
            redirect_valid = 1'b0;
            stall = br_valid && legal;
            illegal_op = br_valid && !legal;
        end
    end
    // legal ops 6..10 map onto comparator codes 22..26
    assign cmp_select = cmp_en ? {2'b01, op_q[3:0]} : 6'd0;
    assign flush = redirect_valid;
    assign redirect_pc = redirect_valid ? target_q : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q <= '0;
            target_q <= '0;
            br_count <= '0;
            taken_count <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q <= br_op;
                target_q <= br_target;
            end
            if (state == RESOLVE) begin
                if (!(&br_count)) br_count <= br_count + CNT_W'(1);
                if (cmp_result && !(&taken_count)) taken_count <= taken_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequencer for the shared branch comparator in the ID stage. Accepts a decoded branch, stalls the front end until the source operands are hazard-free, then drives the comparator select code for one cycle. It samples the comparator outcome and issues a PC redirect plus IF flush when the branch is taken. It also keeps saturating branch and taken-branch statistics counters.

Parameters:
ADDR_W, 32, width of the branch target and redirect PC.
CNT_W, 16, width of the statistics counters.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
br_valid  input  1  ID stage holds a branch instruction
br_op  input  5  branch opcode: 00110 BEQ, 00111 BNE, 01000 BLEZ, 01001 BGTZ, 01010 BGEZ
br_target  input  ADDR_W  computed branch target address
opnd_ready  input  1  both source operands of the ID branch are free of hazards
cmp_result  input  1  comparator outcome, valid in the cycle after cmp_en
cmp_en  output  1  comparator evaluate strobe
cmp_select  output  6  comparator function code
stall  output  1  hold PC and IF/ID
flush  output  1  squash the IF/ID instruction
redirect_valid  output  1  load PC from redirect_pc
redirect_pc  output  ADDR_W  taken-branch target
illegal_op  output  1  br_valid with an unsupported opcode
br_count  output  CNT_W  resolved branches, saturating
taken_count  output  CNT_W  taken branches, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: FSM in IDLE; op, target and both counters cleared.
- Outputs while in reset or IDLE: all outputs 0, except stall and illegal_op, which follow the IDLE rules below.
- States:
  - IDLE: waiting for a branch.
  - WAIT: operands not ready.
  - COMPARE: drive the comparator.
  - RESOLVE: sample the outcome.
- IDLE, legal op: on br_valid with a legal br_op, latch op and br_target.
  - If opnd_ready=1, go to COMPARE.
  - If opnd_ready=0, go to WAIT.
  - stall=1 combinationally in this accept cycle.
- IDLE, illegal op: on br_valid with an illegal br_op, illegal_op=1 combinationally for that cycle.
  - No stall, stay in IDLE, counters unchanged.
- WAIT: stall=1. Go to COMPARE on the first cycle opnd_ready=1. br_op and br_target are ignored (latched copies are used).
- COMPARE: stall=1, cmp_en=1, cmp_select driven from the latched op:
  - BEQ 010110
  - BNE 010111
  - BLEZ 011000
  - BGTZ 011001
  - BGEZ 011010
  - Go to RESOLVE unconditionally.
- cmp_select is 000000 whenever cmp_en=0.
- RESOLVE: stall=0, so the branch leaves ID at the end of this cycle.
  - redirect_valid = flush = cmp_result.
  - redirect_pc = latched target; it is 0 when redirect_valid=0.
  - br_count increments by 1.
  - taken_count increments by 1 if cmp_result=1.
  - Go to IDLE.
  - br_valid in RESOLVE refers to the same instruction and is never accepted as a new branch.
- Latency with operands ready: accept at cycle T, compare at T+1, redirect at T+2. stall is high for T and T+1.
- Latency with operand wait: each cycle in WAIT adds exactly one stall cycle.
- Counter saturation: both counters stick at all-ones with no wrap. taken_count never exceeds br_count.
- Reset mid-operation: rst in any state returns to IDLE next cycle.
  - No redirect and no counter update for the in-flight branch.
  - rst has priority over every other transition.

Test Plan:
1. BEQ, operands ready, cmp_result=1 at T+2.
   - stall=1 at T and T+1; cmp_en=1 with cmp_select=010110 at T+1.
   - At T+2: redirect_valid=flush=1 and redirect_pc=br_target (e.g. 0x00400040), stall=0.
   - After T+2: br_count=1, taken_count=1.
2. BGTZ, opnd_ready=0 for 3 cycles, then 1, cmp_result=0.
   - stall high for 5 cycles; cmp_select=011001 exactly once.
   - No redirect; br_count=1, taken_count=0.
3. br_op=00101 with br_valid.
   - illegal_op=1 that cycle, stall=0, no cmp_en, counters unchanged.
4. rst asserted in the COMPARE cycle of a BNE.
   - Next cycle: all outputs 0, IDLE state, no redirect even with cmp_result=1, counters 0.
5. CNT_W=4, 20 back-to-back taken BGEZ branches.
   - br_count=taken_count=15 (saturated).
   - cmp_select=011010 in every COMPARE cycle.
6. Two consecutive branches, the second held on br_valid through RESOLVE of the first.
   - The second is accepted only in the following IDLE cycle; br_count=2.
